// File: rtl/mac_acc_reader_pkg.sv
// Shared types and the requantize helper (rounding right shift plus saturation)
// used by the MAC result readers.
package mac_acc_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Widest supported result; the accumulator is 2*MAXW and the rounding sum needs one extra bit.
    localparam int MAXW = 32;
    localparam int RW   = 2 * MAXW + 1;

    // acc_ext must already be sign/zero extended to RW bits. Returns {sat, data}.
    function automatic logic [MAXW:0] requant(
        input logic signed [RW-1:0] acc_ext,
        input logic [5:0]           shift,
        input int                   data_w,
        input logic                 is_signed
    );
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] v;
        logic signed [RW-1:0] hi;
        logic signed [RW-1:0] lo;
        logic signed [RW-1:0] clamped;
        logic                 sat;
        r = acc_ext;
        if (shift != 6'd0) begin
            r = r + $signed(RW'(1) << (shift - 6'd1));
        end
        if (is_signed) begin
            v  = r >>> shift;
            hi = $signed((RW'(1) << (data_w - 1)) - RW'(1));
            lo = $signed(-(RW'(1) << (data_w - 1)));
        end else begin
            v  = $signed(r >> shift);
            hi = $signed((RW'(1) << data_w) - RW'(1));
            lo = '0;
        end
        sat     = 1'b0;
        clamped = v;
        if (v > hi) begin
            clamped = hi;
            sat     = 1'b1;
        end else if (v < lo) begin
            clamped = lo;
            sat     = 1'b1;
        end
        return {sat, clamped[MAXW-1:0]};
    endfunction

endpackage

// File: rtl/mac_res_fifo.sv
// Synchronous result FIFO; simultaneous write and read leave occupancy unchanged.
module mac_res_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Credits upstream make a write into a full FIFO impossible.
    wr_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/mac_acc_reader.sv
// Drives operand windows into the 4-stage MAC, captures each window's final
// accumulator, requantizes it and hands results out through a credited FIFO.
//   state    | meaning
//   ST_IDLE  | no job; waiting for start
//   ST_RUN   | accepting operands for the current job
//   ST_DRAIN | all operands sent; waiting for the last result to be handed off
module mac_acc_reader
    import mac_acc_reader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SIGNED     = 1,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LD_DLY     = 2,
    parameter int OUT_DLY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic [CNT_W-1:0]      cfg_windows,
    input  logic [5:0]            cfg_shift,
    input  logic [2*DATA_W-1:0]   cfg_bias,
    output logic                  busy,
    output logic                  done,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic [DATA_W-1:0]     mac_a,
    output logic [DATA_W-1:0]     mac_b,
    output logic [2*DATA_W-1:0]   mac_c,
    output logic                  mac_ld_acc,
    input  logic [2*DATA_W-1:0]   mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic                  res_sat
);
    localparam int ACC_W = 2 * DATA_W;
    localparam int UW    = $clog2(FIFO_DEPTH) + 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     len_q, len_d, win_q, win_d;
    logic [CNT_W-1:0]     term_cnt_q, term_cnt_d, win_cnt_q, win_cnt_d;
    logic [5:0]           shift_q, shift_d;
    logic [ACC_W-1:0]     bias_q, bias_d;
    logic [LD_DLY-1:0]    ld_pipe_q, ld_pipe_d;
    logic [OUT_DLY-1:0]   last_pipe_q, last_pipe_d;
    logic [UW-1:0]        used_q, used_d;
    logic                 zero_done_q, zero_done_d;

    logic                 go, accept, first_term, last_term, last_window, res_pop, drained;
    logic                 fifo_empty, fifo_full_unused;
    logic [UW-1:0]        fifo_count_unused;
    logic signed [RW-1:0] acc_ext;
    logic [MAXW:0]        req;
    logic [DATA_W:0]      fifo_wr_data, fifo_rd_data;

    assign go          = start && (state_q == ST_IDLE) && (cfg_len != '0) && (cfg_windows != '0);
    assign accept      = op_valid && op_ready;
    assign first_term  = (term_cnt_q == '0);
    assign last_term   = (term_cnt_q == len_q - CNT_W'(1));
    assign last_window = (win_cnt_q == win_q - CNT_W'(1));
    assign res_pop     = res_valid && res_ready;
    assign drained     = fifo_empty && (used_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = ST_RUN;
            ST_RUN:   if (accept && last_term && last_window) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A credit covers a whole window, so only a window's first term needs one.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        op_ready = (state_q == ST_RUN) && ((term_cnt_q != '0) || (used_q < UW'(FIFO_DEPTH)));
        done     = zero_done_q || ((state_q == ST_DRAIN) && drained);
    end

    always_comb begin
        len_d       = len_q;
        win_d       = win_q;
        shift_d     = shift_q;
        bias_d      = bias_q;
        term_cnt_d  = term_cnt_q;
        win_cnt_d   = win_cnt_q;
        zero_done_d = start && (state_q == ST_IDLE) && ((cfg_len == '0) || (cfg_windows == '0));
        if (go) begin
            len_d      = cfg_len;
            win_d      = cfg_windows;
            shift_d    = cfg_shift;
            bias_d     = cfg_bias;
            term_cnt_d = '0;
            win_cnt_d  = '0;
        end
        if (accept) begin
            if (last_term) begin
                term_cnt_d = '0;
                win_cnt_d  = win_cnt_q + 1'b1;
            end else begin
                term_cnt_d = term_cnt_q + 1'b1;
            end
        end
        ld_pipe_d   = LD_DLY'({ld_pipe_q, accept && first_term});
        last_pipe_d = OUT_DLY'({last_pipe_q, accept && last_term});
        used_d      = used_q + UW'(accept && first_term) - UW'(res_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            win_q       <= '0;
            shift_q     <= '0;
            bias_q      <= '0;
            term_cnt_q  <= '0;
            win_cnt_q   <= '0;
            ld_pipe_q   <= '0;
            last_pipe_q <= '0;
            used_q      <= '0;
            zero_done_q <= 1'b0;
        end else begin
            len_q       <= len_d;
            win_q       <= win_d;
            shift_q     <= shift_d;
            bias_q      <= bias_d;
            term_cnt_q  <= term_cnt_d;
            win_cnt_q   <= win_cnt_d;
            ld_pipe_q   <= ld_pipe_d;
            last_pipe_q <= last_pipe_d;
            used_q      <= used_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign mac_a      = accept ? op_a : '0;
    assign mac_b      = accept ? op_b : '0;
    assign mac_c      = bias_q;
    assign mac_ld_acc = ld_pipe_q[LD_DLY-1];

    always_comb begin
        if (SIGNED != 0) begin
            acc_ext = {{(RW-ACC_W){mac_out[ACC_W-1]}}, mac_out};
        end else begin
            acc_ext = {{(RW-ACC_W){1'b0}}, mac_out};
        end
        req          = requant(acc_ext, shift_q, DATA_W, SIGNED != 0);
        fifo_wr_data = {req[MAXW], req[DATA_W-1:0]};
    end

    if (DATA_W < MAXW) begin : g_req_unused
        logic req_unused;
        assign req_unused = ^req[MAXW-1:DATA_W];
    end

    mac_res_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (last_pipe_q[OUT_DLY-1]),
        .wr_data (fifo_wr_data),
        .rd_en   (res_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full_unused),
        .empty   (fifo_empty),
        .count   (fifo_count_unused)
    );

    assign res_valid = !fifo_empty;
    assign res_sat   = fifo_rd_data[DATA_W];
    assign res_data  = fifo_rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_mac_acc_reader.sv
// Scoreboard bench for mac_acc_reader with a behavioural 4-stage MAC attached.
module tb_mac_acc_reader;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, busy, done, op_valid, op_ready, mac_ld_acc, res_valid, res_ready, res_sat;
    logic [CW-1:0] cfg_len, cfg_windows;
    logic [5:0]    cfg_shift;
    logic [AW-1:0] cfg_bias, mac_c, mac_out;
    logic [DW-1:0] op_a, op_b, mac_a, mac_b, res_data;

    logic          u1_start, u1_busy, u1_done, u1_op_valid, u1_op_ready, u1_mac_ld_acc;
    logic          u1_res_valid, u1_res_ready, u1_res_sat;
    logic [CW-1:0] u1_cfg_len, u1_cfg_windows;
    logic [5:0]    u1_cfg_shift;
    logic [AW-1:0] u1_cfg_bias, u1_mac_c, u1_mac_out;
    logic [DW-1:0] u1_op_a, u1_op_b, u1_mac_a, u1_mac_b, u1_res_data;

    mac_acc_reader #(.DATA_W(DW), .SIGNED(1), .CNT_W(CW), .FIFO_DEPTH(4), .LD_DLY(2), .OUT_DLY(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_windows(cfg_windows),
        .cfg_shift(cfg_shift), .cfg_bias(cfg_bias), .busy(busy), .done(done),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_ld_acc(mac_ld_acc), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat));

    mac_acc_reader #(.DATA_W(DW), .SIGNED(0), .CNT_W(CW), .FIFO_DEPTH(4), .LD_DLY(2), .OUT_DLY(4)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(u1_start), .cfg_len(u1_cfg_len), .cfg_windows(u1_cfg_windows),
        .cfg_shift(u1_cfg_shift), .cfg_bias(u1_cfg_bias), .busy(u1_busy), .done(u1_done),
        .op_valid(u1_op_valid), .op_ready(u1_op_ready), .op_a(u1_op_a), .op_b(u1_op_b),
        .mac_a(u1_mac_a), .mac_b(u1_mac_b), .mac_c(u1_mac_c), .mac_ld_acc(u1_mac_ld_acc),
        .mac_out(u1_mac_out), .res_valid(u1_res_valid), .res_ready(u1_res_ready),
        .res_data(u1_res_data), .res_sat(u1_res_sat));

    // Behavioural MACs: product, product delay, accumulate (ld_acc loads C + product), output register.
    logic signed [AW-1:0] m1_s = '0, m2_s = '0, acc_s = '0, out_s = '0;
    always @(posedge clk) begin
        m1_s  <= $signed(mac_a) * $signed(mac_b);
        m2_s  <= m1_s;
        acc_s <= mac_ld_acc ? ($signed(mac_c) + m2_s) : (acc_s + m2_s);
        out_s <= acc_s;
    end
    assign mac_out = out_s;

    logic [AW-1:0] m1_u = '0, m2_u = '0, acc_u = '0, out_u = '0;
    always @(posedge clk) begin
        m1_u  <= u1_mac_a * u1_mac_b;
        m2_u  <= m1_u;
        acc_u <= u1_mac_ld_acc ? (u1_mac_c + m2_u) : (acc_u + m2_u);
        out_u <= acc_u;
    end
    assign u1_mac_out = out_u;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW:0] exp_q[$];
    int ld_cnt = 0, ld_last = -1, rv_rise = -1;
    logic rv_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: scoreboard pops, gap-zeroing and pass-through, ld_acc and res_valid timing.
    initial forever begin
        logic [DW:0] e;
        @(negedge clk);
        if (mac_ld_acc) begin
            ld_cnt++;
            ld_last = cyc;
        end
        if (res_valid && !rv_prev) rv_rise = cyc;
        rv_prev = res_valid;
        checks++;
        if (op_valid && op_ready) begin
            if (mac_a != op_a || mac_b != op_b) begin
                errors++;
                $display("FAIL pass_through cycle %0d: mac_a %0d mac_b %0d expected %0d %0d", cyc, mac_a, mac_b, op_a, op_b);
            end
        end else if (mac_a != '0 || mac_b != '0) begin
            errors++;
            $display("FAIL gap_zero cycle %0d: mac_a %0d mac_b %0d expected 0 0", cyc, mac_a, mac_b);
        end
        if (res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result cycle %0d: got sat %0d data %0d", cyc, res_sat, res_data);
            end else begin
                e = exp_q.pop_front();
                if ({res_sat, res_data} != e) begin
                    errors++;
                    $display("FAIL result cycle %0d: got sat %0d data %0d expected sat %0d data %0d",
                             cyc, res_sat, $signed(res_data), e[DW], $signed(e[DW-1:0]));
                end
            end
        end
    end

    task automatic start_job(input int len, input int win, input int sh, input int bias);
        cfg_len     = CW'(len);
        cfg_windows = CW'(win);
        cfg_shift   = 6'(sh);
        cfg_bias    = AW'(bias);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic put_op(input int a, input int b, output int acc_cyc);
        op_valid = 1'b1;
        op_a     = DW'(a);
        op_b     = DW'(b);
        acc_cyc  = -1;
        for (int n = 0; n < 100 && acc_cyc < 0; n++) begin
            @(negedge clk);
            if (op_ready) acc_cyc = cyc;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL op_accept_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic wait_done(input string name, output int done_cyc);
        done_cyc = -1;
        for (int n = 0; n < 500 && done_cyc < 0; n++) begin
            @(negedge clk);
            if (done) done_cyc = cyc;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s_done: got no done pulse expected one within 500 cycles", name);
        end
        @(posedge clk); #1;
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        int t0, t, dc, acc, got, ld0;
        start = 0; cfg_len = 0; cfg_windows = 0; cfg_shift = 0; cfg_bias = 0;
        op_valid = 0; op_a = 0; op_b = 0; res_ready = 1;
        u1_start = 0; u1_cfg_len = 0; u1_cfg_windows = 0; u1_cfg_shift = 0; u1_cfg_bias = 0;
        u1_op_valid = 0; u1_op_a = 0; u1_op_b = 0; u1_res_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_op_ready", op_ready, 0);
        chk("idle_ld_acc", mac_ld_acc, 0);
        chk("idle_mac_c", mac_c, 0);
        chk("idle_res_data", res_data, 0);

        // Zero length or zero windows: done next cycle, nothing else.
        start_job(0, 1, 0, 0);
        @(negedge clk);
        chk("zlen_done", done, 1);
        chk("zlen_busy", busy, 0);
        @(negedge clk);
        chk("zlen_done_once", done, 0);
        @(posedge clk); #1;
        start_job(2, 0, 0, 0);
        @(negedge clk);
        chk("zwin_done", done, 1);
        chk("zwin_busy", busy, 0);
        @(posedge clk); #1;

        // 2*3 + (-1)*4 + 5*5 = 27, back-to-back operands.
        ld0 = ld_cnt;
        exp_q.push_back({1'b0, 8'd27});
        start_job(3, 1, 0, 0);
        chk("t1_busy", busy, 1);
        put_op(2, 3, t0);
        put_op(-1, 4, t);
        put_op(5, 5, t);
        chk("t1_back_to_back", t, t0 + 2);
        wait_done("t1", dc);
        chk("t1_ld_count", ld_cnt - ld0, 1);
        chk("t1_ld_cycle", ld_last, t0 + 2);
        chk("t1_res_cycle", rv_rise, t0 + 7);
        chk("t1_done_cycle", dc, t0 + 8);

        // (20000 + 8) >> 4 = 1250 saturates to 127.
        exp_q.push_back({1'b1, 8'd127});
        start_job(2, 1, 4, 0);
        put_op(100, 100, t);
        put_op(100, 100, t);
        wait_done("t2", dc);

        // (-7 + 1) >>> 1 = -3.
        exp_q.push_back({1'b0, 8'hFD});
        start_job(1, 1, 1, -7);
        put_op(0, 0, t);
        wait_done("t3", dc);

        // Unsigned instance: (7 + 1) >> 1 = 4.
        u1_cfg_len = 1; u1_cfg_windows = 1; u1_cfg_shift = 1; u1_cfg_bias = 16'd7;
        u1_start = 1'b1;
        @(posedge clk); #1;
        u1_start = 1'b0;
        u1_op_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(negedge clk);
            if (u1_op_ready) got = 1;
            @(posedge clk); #1;
        end
        u1_op_valid = 1'b0;
        chk("u_accept", got, 1);
        got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(negedge clk);
            if (u1_res_valid) begin
                got = 1;
                chk("u_res_data", u1_res_data, 4);
                chk("u_res_sat", u1_res_sat, 0);
            end
        end
        chk("u_res_seen", got, 1);
        @(posedge clk); #1;

        // Credit limit: six 1-term windows with the consumer stalled.
        res_ready = 1'b0;
        for (int i = 1; i <= 6; i++) exp_q.push_back({1'b0, 8'(i)});
        start_job(1, 6, 0, 0);
        op_valid = 1'b1; op_a = 8'd1; op_b = 8'd1;
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            if (op_ready) acc++;
            @(posedge clk); #1;
            op_a = DW'(acc + 1);
        end
        op_valid = 1'b0;
        @(negedge clk);
        chk("t4_accepts", acc, 4);
        chk("t4_op_ready_low", op_ready, 0);
        chk("t4_res_valid_held", res_valid, 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        put_op(5, 1, t);
        put_op(6, 1, t);
        wait_done("t4", dc);

        // Random gaps inside windows: 10 + 4*1 = 14 per window.
        for (int w = 0; w < 3; w++) exp_q.push_back({1'b0, 8'd14});
        start_job(4, 3, 0, 10);
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            put_op(1, 1, t);
        end
        wait_done("t5", dc);

        // Reset in window 2 of 3, then a fresh job: 1 + 3*4 + 5*6 = 43.
        start_job(2, 3, 0, 5);
        put_op(1, 1, t);
        put_op(1, 1, t);
        put_op(1, 1, t);
        op_valid = 1'b1; op_a = 8'd3; op_b = 8'd3;
        rst_n = 1'b0;
        #2;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_op_ready", op_ready, 0);
        chk("t6_rst_mac_a", mac_a, 0);
        chk("t6_rst_mac_b", mac_b, 0);
        chk("t6_rst_mac_c", mac_c, 0);
        chk("t6_rst_ld_acc", mac_ld_acc, 0);
        chk("t6_rst_res_valid", res_valid, 0);
        chk("t6_rst_res_data", res_data, 0);
        chk("t6_rst_res_sat", res_sat, 0);
        op_valid = 1'b0; op_a = '0; op_b = '0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'd43});
        start_job(2, 1, 0, 1);
        put_op(3, 4, t);
        put_op(5, 6, t);
        wait_done("t6", dc);

        repeat (10) @(posedge clk);
        #1;
        chk("final_no_stray_result", res_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
